alu_uart_interface: RTL and testbench

Sequential front-end that feeds the ALU from a byte stream and returns its result. It collects three bytes from the UART receiver (operand A, operand B, opcode) and drives them onto the ALU operand/opcode inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between `uart_rx`/`uart_tx` and the combinational ALU, and is the system's only producer of ALU operands and only consumer of ALU results.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/frame_timer.sv | 37 +++
 rtl/alu_uart_interface.sv | 146 ++++++++++++++
 tb/tb_alu_uart_interface.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU byte-stream front-end: default widths, ALU opcodes
// and the frame FSM state encoding.
package alu_pkg;

    localparam int unsigned NB_DATA_DEFAULT   = 8;
    localparam int unsigned NB_OPCODE_DEFAULT = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StSend,
        StWaitTx
    } state_e;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: clear has priority, counts while enabled and saturates
// at TIMEOUT_CYCLES-1, where expired is raised.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, presents them to
// the combinational ALU and hands the captured result to the UART transmitter.
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DEFAULT,
    parameter int unsigned NB_OPCODE      = NB_OPCODE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NB_DATA-1:0]   rx_data,
    input  logic                 rx_done,
    input  logic [NB_DATA-1:0]   alu_result,
    output logic [NB_DATA-1:0]   dato_a,
    output logic [NB_DATA-1:0]   dato_b,
    output logic [NB_OPCODE-1:0] opcode,
    output logic [NB_DATA-1:0]   tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 overrun,
    output logic                 frame_err
);

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    logic in_frame, tmr_clear, tmr_enable, tmr_expired, timeout;

    // Only the gaps inside a frame are timed; an accepted byte restarts the window.
    assign in_frame   = (state_q == StWaitB) || (state_q == StWaitOp);
    assign tmr_clear  = rx_done || !in_frame;
    assign tmr_enable = in_frame && !rx_done;
    assign timeout    = in_frame && !rx_done && tmr_expired;

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        dato_a_d    = dato_a_q;
        dato_b_d    = dato_b_q;
        opcode_d    = opcode_q;
        tx_data_d   = tx_data_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StWaitA: begin
                if (rx_done) begin
                    dato_a_d = rx_data;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (rx_done) begin
                    dato_b_d = rx_data;
                    state_d  = StWaitOp;
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = StWaitA;
                end
            end
            StWaitOp: begin
                if (rx_done) begin
                    opcode_d = rx_data[NB_OPCODE-1:0];
                    state_d  = StExec;
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = StWaitA;
                end
            end
            StExec: begin
                tx_data_d = alu_result;
                overrun_d = rx_done;
                state_d   = StSend;
            end
            StSend: begin
                overrun_d = rx_done;
                state_d   = StWaitTx;
            end
            StWaitTx: begin
                overrun_d = rx_done;
                if (tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: begin
                state_d = StWaitA;
            end
        endcase

        // Registered from the next state so both line up with the state they describe.
        busy_d     = (state_d == StExec) || (state_d == StSend) || (state_d == StWaitTx);
        tx_start_d = (state_d == StSend);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWaitA;
            dato_a_q    <= '0;
            dato_b_q    <= '0;
            opcode_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dato_a_q    <= dato_a_d;
            dato_b_q    <= dato_b_d;
            opcode_q    <= opcode_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dato_a    = dato_a_q;
    assign dato_b    = dato_b_q;
    assign opcode    = opcode_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface: table vectors, hand-written corner
// sequences and randomized frames against a behavioural ALU/frame model.
module tb_alu_uart_interface;
    import alu_pkg::*;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic [7:0] dato_a, dato_b, tx_data;
    logic [5:0] opcode;
    logic       tx_start, tx_done, busy, overrun, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_ovr   = 0;
    int n_ferr  = 0;

    alu_uart_interface #(
        .NB_DATA        (8),
        .NB_OPCODE      (6),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .alu_result (alu_result),
        .dato_a     (dato_a),
        .dato_b     (dato_b),
        .opcode     (opcode),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return sa >>> b;
            OP_SRL:  return a >> b;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    // Behavioural stand-in for the real ALU.
    always_comb alu_result = alu_ref(dato_a, dato_b, opcode);

    always @(posedge clk) begin
        if (tx_start)  n_start <= n_start + 1;
        if (overrun)   n_ovr   <= n_ovr + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " dato_a"},    32'(dato_a),    32'h0);
        check({tag, " dato_b"},    32'(dato_b),    32'h0);
        check({tag, " opcode"},    32'(opcode),    32'h0);
        check({tag, " tx_data"},   32'(tx_data),   32'h0);
        check({tag, " tx_start"},  32'(tx_start),  32'h0);
        check({tag, " busy"},      32'(busy),      32'h0);
        check({tag, " overrun"},   32'(overrun),   32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
    endtask

    // One full frame with cycle-exact checks. novr bytes are thrown at WAIT_TX;
    // coincide also pulses rx_done together with tx_done.
    task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [7:0] exp, input int gap,
                            input int novr, input bit coincide);
        int s0, o0;
        send_byte(a);
        check({tag, " dato_a"}, 32'(dato_a), 32'(a));
        repeat (gap) tick();
        send_byte(b);
        check({tag, " dato_b"}, 32'(dato_b), 32'(b));
        repeat (gap) tick();
        s0 = n_start;
        send_byte(opb);                                 // now cycle N+1
        check({tag, " opcode"}, 32'(opcode), 32'(opb[5:0]));
        check({tag, " busy N+1"}, 32'(busy), 32'h1);
        check({tag, " tx_start N+1"}, 32'(tx_start), 32'h0);
        tick();                                         // N+2
        check({tag, " tx_start N+2"}, 32'(tx_start), 32'h1);
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp));
        tick();                                         // N+3
        check({tag, " tx_start N+3"}, 32'(tx_start), 32'h0);
        check({tag, " tx_start count"}, 32'(n_start), 32'(s0 + 1));
        o0 = n_ovr;
        for (int k = 0; k < novr; k++) begin
            send_byte(8'h77);
            tick();
        end
        check({tag, " overrun count"}, 32'(n_ovr), 32'(o0 + novr));
        tx_done = 1'b1;
        if (coincide) begin
            rx_data = 8'h77;
            rx_done = 1'b1;
        end
        tick();
        tx_done = 1'b0;
        rx_done = 1'b0;
        check({tag, " busy after tx_done"}, 32'(busy), 32'h0);
        check({tag, " overrun after tx_done"}, 32'(overrun), 32'(coincide));
        check({tag, " dato_a held"}, 32'(dato_a), 32'(a));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] res;
    } vec_t;

    vec_t       vecs[10];
    logic [5:0] ops[8];

    initial begin
        int s0, e0;
        logic [7:0] ra, rb, rop;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};  // ADD
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};  // SUB
        vecs[2] = '{8'hF0, 8'h3C, 8'h26, 8'hCC};  // XOR
        vecs[3] = '{8'hAA, 8'h0F, 8'h24, 8'h0A};  // AND
        vecs[4] = '{8'hAA, 8'h0F, 8'h25, 8'hAF};  // OR
        vecs[5] = '{8'h0F, 8'hF0, 8'h27, 8'h00};  // NOR
        vecs[6] = '{8'h80, 8'h03, 8'h03, 8'hF0};  // SRA
        vecs[7] = '{8'h80, 8'h03, 8'h02, 8'h10};  // SRL
        vecs[8] = '{8'h05, 8'h03, 8'hE0, 8'h08};  // upper opcode bits dropped
        vecs[9] = '{8'hFF, 8'h01, 8'h20, 8'h00};  // ADD wraps
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

        reset   = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_vals("por");

        for (int i = 0; i < 10; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].res,
                     i % 3, 0, 1'b0);
        end

        // Timeout after operand A: T idle cycles in WAIT_B.
        e0 = n_ferr;
        send_byte(8'h05);
        repeat (T - 1) tick();
        check("timeout no early frame_err", 32'(frame_err), 32'h0);
        tick();
        check("timeout frame_err", 32'(frame_err), 32'h1);
        check("timeout busy", 32'(busy), 32'h0);
        tick();
        check("timeout frame_err one cycle", 32'(frame_err), 32'h0);
        check("timeout frame_err count", 32'(n_ferr), 32'(e0 + 1));
        check("timeout dato_a held", 32'(dato_a), 32'h05);
        do_frame("after timeout", 8'h01, 8'h01, 8'h20, 8'h02, 0, 0, 1'b0);

        // Byte arriving in the expiry cycle is accepted, no frame_err.
        e0 = n_ferr;
        do_frame("expiry edge", 8'h11, 8'h22, 8'h20, 8'h33, T - 1, 0, 1'b0);
        check("expiry edge no frame_err", 32'(n_ferr), 32'(e0));

        // Overruns in WAIT_TX, including coincident with tx_done.
        do_frame("overrun", 8'h10, 8'h20, 8'h25, 8'h30, 0, 2, 1'b1);
        check("overrun next frame A", 32'(dato_a), 32'h10);
        do_frame("after overrun", 8'h09, 8'h04, 8'h22, 8'h05, 0, 0, 1'b0);

        // Reset after two bytes.
        send_byte(8'h12);
        send_byte(8'h34);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("reset mid-frame");
        do_frame("after reset mid", 8'h21, 8'h12, 8'h20, 8'h33, 0, 0, 1'b0);

        // Reset while in SEND.
        send_byte(8'h40);
        send_byte(8'h02);
        s0 = n_start;
        send_byte(8'h20);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("reset in send");
        repeat (3) tick();
        check("reset in send no new tx_start", 32'(n_start), 32'(s0 + 1));
        check("reset in send tx_start low", 32'(tx_start), 32'h0);
        do_frame("after reset send", 8'h40, 8'h02, 8'h20, 8'h42, 0, 0, 1'b0);

        // Randomized frames against the reference model.
        for (int i = 0; i < 40; i++) begin
            int gap;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rop = 8'($urandom);
            else rop = {2'($urandom), ops[$urandom_range(0, 7)]};
            gap = ($urandom_range(0, 7) == 0) ? int'(T - 1) : int'($urandom_range(0, 5));
            do_frame($sformatf("rand%0d", i), ra, rb, rop, alu_ref(ra, rb, rop[5:0]), gap,
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
